// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace packet arbiter.
// The optional per-packet source header is enabled by TRDB_ARB_SRC_HEADER_EN.
package trdb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HDR    = 2'd1,
        ARB_STREAM = 2'd2
    } arb_state_e;

    localparam logic [7:0] ARB_HDR_MAGIC = 8'hA5;

    // Source index width, never narrower than one bit.
    function automatic int src_idx_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/trdb_packet_arbiter_if.sv
// Requester-side and sink-side handshake bundle of the trace packet arbiter.
// Signal suffixes are from the arbiter's point of view.
interface trdb_packet_arbiter_if
    import trdb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int WORD_W  = 32
);
    localparam int SRC_W = src_idx_w(NUM_SRC);

    logic [NUM_SRC*WORD_W-1:0] src_word_i;
    logic [NUM_SRC-1:0]        src_valid_i;
    logic [NUM_SRC-1:0]        src_last_i;
    logic [NUM_SRC-1:0]        src_stall_o;
    logic [WORD_W-1:0]         packet_word_o;
    logic                      packet_word_valid_o;
    logic                      packet_last_o;
    logic [SRC_W-1:0]          packet_src_o;
    logic                      stall_i;

    modport master (
        input  src_word_i, src_valid_i, src_last_i, stall_i,
        output src_stall_o, packet_word_o, packet_word_valid_o, packet_last_o, packet_src_o
    );

    modport slave (
        output src_word_i, src_valid_i, src_last_i, stall_i,
        input  src_stall_o, packet_word_o, packet_word_valid_o, packet_last_o, packet_src_o
    );

endinterface

// File: rtl/trdb_rr_picker.sv
// Round-robin search: first asserted request at or after the pointer, wrapping.
module trdb_rr_picker
    import trdb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SRC_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [SRC_W-1:0]   idx_o
);

    always_comb begin
        int                sum;
        logic [SRC_W-1:0]  cand;
        found_o = 1'b0;
        idx_o   = '0;
        sum     = 0;
        cand    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            sum = int'(ptr_i) + k;
            if (sum >= NUM_SRC) begin
                sum = sum - NUM_SRC;
            end
            cand = SRC_W'(sum);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/trdb_packet_arbiter.sv
// Packet-locked round-robin arbiter sharing one trace sink between NUM_SRC sources.
// Define TRDB_ARB_SRC_HEADER_EN to prefix each packet with an 0xA5 source header word.
module trdb_packet_arbiter
    import trdb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int WORD_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    trdb_packet_arbiter_if.master arb_if,
    output logic                  busy_o
);

    localparam int SRC_W = src_idx_w(NUM_SRC);

    arb_state_e        state_q, state_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_word_q, out_word_d;
    logic              out_last_q, out_last_d;
    logic [SRC_W-1:0]  out_src_q, out_src_d;

    logic              can_accept;
    logic              pick_found;
    logic [SRC_W-1:0]  pick_idx;
    logic [WORD_W-1:0] gnt_word;
    logic              gnt_valid;
    logic              gnt_last;
    logic              take_word;
    logic [SRC_W-1:0]  next_ptr;

    trdb_rr_picker #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_picker (
        .req_i   (arb_if.src_valid_i),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign can_accept = !out_valid_q || !arb_if.stall_i;
    assign gnt_word   = arb_if.src_word_i[int'(grant_q)*WORD_W +: WORD_W];
    assign gnt_valid  = arb_if.src_valid_i[grant_q];
    assign gnt_last   = arb_if.src_last_i[grant_q];
    assign take_word  = (state_q == ARB_STREAM) && gnt_valid && can_accept;
    assign next_ptr   = (grant_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_q + SRC_W'(1);

    // Only the locked source may move, and only when the output stage has room.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            arb_if.src_stall_o[i] = !((state_q == ARB_STREAM) && can_accept &&
                                      (grant_q == SRC_W'(i)));
        end
    end

`ifdef TRDB_ARB_SRC_HEADER_EN
    logic [WORD_W-1:0] hdr_word;

    always_comb begin
        hdr_word                      = '0;
        hdr_word[WORD_W-1 -: 8]       = ARB_HDR_MAGIC;
        hdr_word[SRC_W-1:0]           = grant_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        // A word that the sink takes this cycle leaves the register unless refilled below.
        if (can_accept) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ARB_IDLE: begin
                if (enable_i && pick_found) begin
                    grant_d = pick_idx;
`ifdef TRDB_ARB_SRC_HEADER_EN
                    state_d = ARB_HDR;
`else
                    state_d = ARB_STREAM;
`endif
                end
            end
`ifdef TRDB_ARB_SRC_HEADER_EN
            ARB_HDR: begin
                if (can_accept) begin
                    out_valid_d = 1'b1;
                    out_word_d  = hdr_word;
                    out_last_d  = 1'b0;
                    out_src_d   = grant_q;
                    state_d     = ARB_STREAM;
                end
            end
`endif
            ARB_STREAM: begin
                if (take_word) begin
                    out_valid_d = 1'b1;
                    out_word_d  = gnt_word;
                    out_last_d  = gnt_last;
                    out_src_d   = grant_q;
                    if (gnt_last) begin
                        rr_ptr_d = next_ptr;
                        state_d  = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign arb_if.packet_word_o       = out_word_q;
    assign arb_if.packet_word_valid_o = out_valid_q;
    assign arb_if.packet_last_o       = out_last_q;
    assign arb_if.packet_src_o        = out_src_q;
    assign busy_o = (state_q != ARB_IDLE) || out_valid_q;

endmodule

// File: tb/tb_trdb_packet_arbiter.sv
// Self-checking bench: cycle vector table, hand-written corner sequences and a
// randomized packet-level scoreboard for trdb_packet_arbiter.
module tb_trdb_packet_arbiter;

    localparam int NUM_SRC = 4;
    localparam int WORD_W  = 32;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trdb_packet_arbiter_if #(.NUM_SRC(NUM_SRC), .WORD_W(WORD_W)) arb_if ();

    trdb_packet_arbiter #(.NUM_SRC(NUM_SRC), .WORD_W(WORD_W)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (enable),
        .arb_if   (arb_if),
        .busy_o   (busy)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic        stall;
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_valid;
        logic        chk_data;
        logic [31:0] exp_word;
        logic        exp_last;
        logic [1:0]  exp_src;
        logic        exp_busy;
        logic [3:0]  exp_sstall;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_src(input int s, input logic v, input logic l, input logic [31:0] w);
        arb_if.src_valid_i[s]          = v;
        arb_if.src_last_i[s]           = l;
        arb_if.src_word_i[s*32 +: 32]  = w;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        enable = 1'b0;
        arb_if.stall_i = 1'b0;
        arb_if.src_valid_i = '0;
        arb_if.src_last_i = '0;
        arb_if.src_word_i = '0;
        step();
    endtask

    task automatic apply_stimulus(input vec_t v);
        step();
        rst = v.rst;
        enable = v.en;
        arb_if.stall_i = v.stall;
        for (int s = 0; s < NUM_SRC; s++) begin
            set_src(s, v.valid[s], v.last[s], (s == 0) ? v.w0 : ((s == 1) ? v.w1 : 32'h0));
        end
        @(negedge clk);
    endtask

    // Scoreboard state for the randomized test.
    logic [31:0] drv_word [NUM_SRC][$];
    bit          drv_last [NUM_SRC][$];
    logic [31:0] exp_word [NUM_SRC][$];
    bit          exp_last [NUM_SRC][$];
    bit          drv_start [NUM_SRC];
    bit          acc [NUM_SRC];
    int          cur_src;
    int          rr_model;
    int          remaining;

    function automatic int pick_model(input int p);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (exp_word[(p + k) % NUM_SRC].size() > 0) return (p + k) % NUM_SRC;
        end
        return -1;
    endfunction

    task automatic model_check();
        if (cur_src < 0) begin
            cur_src = pick_model(rr_model);
            if (cur_src < 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rand_extra actual=%0h expected=no word", arb_if.packet_word_o);
                return;
            end
`ifdef TRDB_ARB_SRC_HEADER_EN
            check_output("rand_hdr_word", arb_if.packet_word_o, {8'hA5, 22'h0, 2'(cur_src)});
            check_output("rand_hdr_last", 32'(arb_if.packet_last_o), 32'h0);
            check_output("rand_hdr_src", 32'(arb_if.packet_src_o), 32'(cur_src));
            return;
`endif
        end
        check_output("rand_src", 32'(arb_if.packet_src_o), 32'(cur_src));
        check_output("rand_word", arb_if.packet_word_o, exp_word[cur_src][0]);
        check_output("rand_last", 32'(arb_if.packet_last_o), 32'(exp_last[cur_src][0]));
        void'(exp_word[cur_src].pop_front());
        remaining--;
        if (exp_last[cur_src].pop_front()) begin
            rr_model = (cur_src + 1) % NUM_SRC;
            cur_src = -1;
        end
    endtask

    vec_t tbl [13];

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        arb_if.stall_i = 1'b0;
        arb_if.src_valid_i = '0;
        arb_if.src_last_i = '0;
        arb_if.src_word_i = '0;

`ifndef TRDB_ARB_SRC_HEADER_EN
        //            rst  en   st   valid   last    w0     w1     ev   cd   eword  el   es   eb   esstall
        tbl[0]  = '{1'b0,1'b1,1'b0,4'b0001,4'b0000,32'h11,32'h0 ,1'b0,1'b1,32'h0 ,1'b0,2'd0,1'b0,4'hF};
        tbl[1]  = '{1'b0,1'b1,1'b0,4'b0001,4'b0000,32'h11,32'h0 ,1'b0,1'b0,32'h0 ,1'b0,2'd0,1'b1,4'hE};
        tbl[2]  = '{1'b0,1'b1,1'b0,4'b0001,4'b0000,32'h22,32'h0 ,1'b1,1'b1,32'h11,1'b0,2'd0,1'b1,4'hE};
        tbl[3]  = '{1'b0,1'b1,1'b0,4'b0001,4'b0001,32'h33,32'h0 ,1'b1,1'b1,32'h22,1'b0,2'd0,1'b1,4'hE};
        tbl[4]  = '{1'b0,1'b1,1'b0,4'b0000,4'b0000,32'h0 ,32'h0 ,1'b1,1'b1,32'h33,1'b1,2'd0,1'b1,4'hF};
        tbl[5]  = '{1'b0,1'b1,1'b0,4'b0000,4'b0000,32'h0 ,32'h0 ,1'b0,1'b0,32'h0 ,1'b0,2'd0,1'b0,4'hF};
        tbl[6]  = '{1'b0,1'b1,1'b0,4'b0010,4'b0000,32'h0 ,32'hA1,1'b0,1'b0,32'h0 ,1'b0,2'd0,1'b0,4'hF};
        tbl[7]  = '{1'b0,1'b1,1'b0,4'b0010,4'b0000,32'h0 ,32'hA1,1'b0,1'b0,32'h0 ,1'b0,2'd0,1'b1,4'hD};
        tbl[8]  = '{1'b1,1'b1,1'b0,4'b0010,4'b0000,32'h0 ,32'hA2,1'b1,1'b1,32'hA1,1'b0,2'd1,1'b1,4'hD};
        tbl[9]  = '{1'b0,1'b1,1'b0,4'b0011,4'b0001,32'h55,32'hA2,1'b0,1'b1,32'h0 ,1'b0,2'd0,1'b0,4'hF};
        tbl[10] = '{1'b0,1'b1,1'b0,4'b0011,4'b0001,32'h55,32'hA2,1'b0,1'b0,32'h0 ,1'b0,2'd0,1'b1,4'hE};
        tbl[11] = '{1'b0,1'b1,1'b0,4'b0010,4'b0000,32'h0 ,32'hA2,1'b1,1'b1,32'h55,1'b1,2'd0,1'b1,4'hF};
        tbl[12] = '{1'b0,1'b1,1'b0,4'b0010,4'b0000,32'h0 ,32'hA2,1'b0,1'b0,32'h0 ,1'b0,2'd0,1'b1,4'hD};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(tbl[i]);
            check_output($sformatf("tbl%0d_valid", i), 32'(arb_if.packet_word_valid_o), 32'(tbl[i].exp_valid));
            check_output($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
            check_output($sformatf("tbl%0d_sstall", i), 32'(arb_if.src_stall_o), 32'(tbl[i].exp_sstall));
            if (tbl[i].chk_data) begin
                check_output($sformatf("tbl%0d_word", i), arb_if.packet_word_o, tbl[i].exp_word);
                check_output($sformatf("tbl%0d_last", i), 32'(arb_if.packet_last_o), 32'(tbl[i].exp_last));
                check_output($sformatf("tbl%0d_src", i), 32'(arb_if.packet_src_o), 32'(tbl[i].exp_src));
            end
        end

        // Source 2 pauses mid-packet and enable drops; source 3 must wait its turn.
        do_reset();
        step();
        rst = 1'b0;
        enable = 1'b1;
        set_src(2, 1'b1, 1'b0, 32'h201);
        set_src(3, 1'b1, 1'b1, 32'h301);
        step();
        @(negedge clk);
        check_output("gap_lock_sstall", 32'(arb_if.src_stall_o), 32'hB);
        for (int c = 0; c < 3; c++) begin
            step();
            set_src(2, 1'b0, 1'b0, 32'h0);
            enable = 1'b0;
            @(negedge clk);
            check_output($sformatf("gap%0d_sstall", c), 32'(arb_if.src_stall_o), 32'hB);
            check_output($sformatf("gap%0d_busy", c), 32'(busy), 32'h1);
        end
        step();
        set_src(2, 1'b1, 1'b1, 32'h202);
        step();
        set_src(2, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_output("gap_end_word", arb_if.packet_word_o, 32'h202);
        check_output("gap_end_src", 32'(arb_if.packet_src_o), 32'h2);
        check_output("gap_end_last", 32'(arb_if.packet_last_o), 32'h1);
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            check_output($sformatf("dis%0d_busy", c), 32'(busy), 32'h0);
            check_output($sformatf("dis%0d_sstall", c), 32'(arb_if.src_stall_o), 32'hF);
        end
        step();
        enable = 1'b1;
        step();
        @(negedge clk);
        check_output("reen_sstall", 32'(arb_if.src_stall_o), 32'h7);
        step();
        set_src(3, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_output("reen_word", arb_if.packet_word_o, 32'h301);
        check_output("reen_src", 32'(arb_if.packet_src_o), 32'h3);
`else
        // One-word packet from source 2 is preceded by its header word.
        do_reset();
        step();
        rst = 1'b0;
        enable = 1'b1;
        set_src(2, 1'b1, 1'b1, 32'hDEAD);
        step();
        @(negedge clk);
        check_output("hdr_state_sstall", 32'(arb_if.src_stall_o), 32'hF);
        step();
        @(negedge clk);
        check_output("hdr_word", arb_if.packet_word_o, 32'hA5000002);
        check_output("hdr_last", 32'(arb_if.packet_last_o), 32'h0);
        check_output("hdr_src", 32'(arb_if.packet_src_o), 32'h2);
        check_output("hdr_sstall", 32'(arb_if.src_stall_o), 32'hB);
        step();
        set_src(2, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check_output("hdr_data_word", arb_if.packet_word_o, 32'h0000DEAD);
        check_output("hdr_data_last", 32'(arb_if.packet_last_o), 32'h1);
        check_output("hdr_data_valid", 32'(arb_if.packet_word_valid_o), 32'h1);
`endif

        // Randomized packets from all sources with random gaps and downstream stalls.
        do_reset();
        remaining = 0;
        cur_src = -1;
        rr_model = 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            int npkt;
            npkt = (s == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(0, 5));
            drv_start[s] = 1'b1;
            acc[s] = 1'b0;
            for (int p = 0; p < npkt; p++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) begin
                    drv_word[s].push_back({8'(s), 8'(p), 16'(k)});
                    drv_last[s].push_back(k == len - 1);
                    exp_word[s].push_back({8'(s), 8'(p), 16'(k)});
                    exp_last[s].push_back(k == len - 1);
                    remaining++;
                end
            end
        end
        step();
        rst = 1'b0;
        enable = 1'b1;
        for (int cyc = 0; cyc < 4000 && remaining > 0; cyc++) begin
            step();
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s]) begin
                    drv_start[s] = drv_last[s].pop_front();
                    void'(drv_word[s].pop_front());
                end
                if (drv_word[s].size() > 0) begin
                    set_src(s, drv_start[s] || ($urandom_range(0, 3) != 0), drv_last[s][0], drv_word[s][0]);
                end else begin
                    set_src(s, 1'b0, 1'b0, 32'h0);
                end
            end
            arb_if.stall_i = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            for (int s = 0; s < NUM_SRC; s++) begin
                acc[s] = arb_if.src_valid_i[s] && !arb_if.src_stall_o[s];
            end
            if (arb_if.packet_word_valid_o && !arb_if.stall_i) begin
                model_check();
            end
        end
        check_output("rand_drain_remaining", 32'(remaining), 32'h0);
        arb_if.stall_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_output("rand_final_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trdb_packet_arbiter.md
Name: trdb_packet_arbiter

Overview:
- Shares one trace packet sink (off-chip port, memory writer or stream FIFO) between NUM_SRC trace_debugger instances, one per core.
- Each requester drives packet_word/packet_word_valid and takes a stall back; the arbiter drives the same stall-style handshake downstream.
- Grants round-robin and locks onto a source for a whole packet, so words from different cores never interleave.
- Single registered output stage.

Parameters:
- NUM_SRC, 4, number of trace_debugger requesters (>= 2)
- WORD_W, 32, packet word width in bits
- SRC_W, $clog2(NUM_SRC), source index width (derived localparam, minimum 1)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; active-high, synchronous to clk_i
- enable_i  in  1  allow new grants; low = finish current packet, then idle
- src_word_i  in  NUM_SRC*WORD_W  packed packet words, source i at [i*WORD_W +: WORD_W]
- src_valid_i  in  NUM_SRC  word valid per source
- src_last_i  in  NUM_SRC  word is last of its packet
- src_stall_o  out  NUM_SRC  per-source stall (the trace_debugger stall_i)
- packet_word_o  out  WORD_W  arbitrated word
- packet_word_valid_o  out  1  output valid
- packet_last_o  out  1  last word of packet
- packet_src_o  out  SRC_W  index of the source that owns the current word
- stall_i  in  1  downstream stall
- busy_o  out  1  high whenever state != IDLE or the output register is valid

Behaviour:
- Transfer rule, both sides: a word moves on a cycle with valid && !stall.
- Reset values (next edge with rst_i=1):
  - state IDLE, rr pointer 0
  - packet_word_valid_o 0, packet_word_o 0, packet_last_o 0, packet_src_o 0
  - src_stall_o all 1; busy_o 0
  - any partial packet is dropped.
- Output register:
  - can accept when !packet_word_valid_o || !stall_i.
  - while valid && stall_i, word, last and src hold stable.
- src_stall_o[i] is combinational: 0 only when state == STREAM, grant == i and the output register can accept; otherwise 1.
- FSM:
  - IDLE: if enable_i and any src_valid_i, pick the first valid index at or after rr pointer (wrapping modulo NUM_SRC), latch grant, go to STREAM. Otherwise stay.
  - STREAM: each accepted source word is loaded into the output register (latency 1 cycle). When the accepted word has src_last_i=1: rr pointer <= (grant+1) mod NUM_SRC, go to IDLE.
  - One bubble cycle per packet (the IDLE arbitration cycle).
- Boundary conditions:
  - Granted source drops valid mid-packet: stay locked in STREAM and wait. Other sources stay stalled.
  - enable_i falling mid-packet: packet completes; no further grant.
  - Single-word packet (valid && last on first word): goes back to IDLE after one word.
  - Request from the rr-pointer index in IDLE wins over all others.
  - All sources valid continuously: grant order 0,1,...,NUM_SRC-1,0,...
  - The IDLE cycle also drains the output register normally; no output word is lost or duplicated.

Optional Feature:
- Macro TRDB_ARB_SRC_HEADER_EN.
- Defined:
  - FSM gains state HDR between IDLE and STREAM.
  - HDR loads one header word into the output register when it can accept:
    - [WORD_W-1:WORD_W-8] = 8'hA5, low SRC_W bits = grant, rest 0
    - packet_last_o 0, packet_src_o = grant
  - Then goes to STREAM. All src_stall_o stay 1 in HDR.
- Undefined: no HDR state; IDLE goes straight to STREAM; the stream carries no headers.

Decomposition:
- trdb_pkg holds:
  - arbiter state enum (IDLE, HDR, STREAM)
  - ARB_HDR_MAGIC = 8'hA5
- One combinational sub-module, trdb_rr_picker: inputs request vector and pointer; outputs found flag and index.

Test Plan:
- Src 0 sends a 3-word packet (0x11,0x22,0x33 last) into idle arbiter, stall_i=0, valid seen in cycle 0 -> output words 0x11,0x22,0x33 valid in cycles 2,3,4, last on 0x33, packet_src_o=0, busy_o low from cycle 5.
- All 4 sources hold 2-word packets -> output packets from sources 0,1,2,3,0 in order, never interleaved, one bubble between packets.
- stall_i held high 5 cycles during word 2 of src 1's packet -> output stable, src_stall_o[1]=1, sequence resumes with no loss or duplicate.
- Src 2 drops valid for 3 cycles mid-packet while src 3 is valid -> src_stall_o[3] stays 1, src 2's packet completes before src 3 is granted.
- enable_i low during a packet -> packet completes, no new grant, busy_o falls; rst_i mid-packet -> next cycle valid 0, all src_stall_o 1, next grant starts from source 0.
- With TRDB_ARB_SRC_HEADER_EN, src 2 one-word packet 0xDEAD -> output 0xA5000002 (last 0) then 0x0000DEAD (last 1).
